// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-aligned
// load/ack handover and optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic        ack,
    output logic        pending,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_d_q, pend_d_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_lz_q, pend_lz_d;
    logic          pending_q, pending_d;
    logic [15:0]   disp_d_q, disp_d_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic          disp_lz_q, disp_lz_d;
    logic          ack_q, ack_d;
    logic [3:0]    bcd_out_q, bcd_out_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;

    logic          tcnt_last;
    logic          commit;
    logic          in_guard;
    logic [3:0]    blank;
    logic [3:0]    sel_digit;

    always_comb begin
        tcnt_last = (tcnt_q == LAST);
        commit    = tcnt_last && (idx_q == 2'd3) && pending_q;
        in_guard  = (tcnt_q < GUARD_C);

        tcnt_d = tcnt_last ? '0 : tcnt_q + 1'b1;
        idx_d  = tcnt_last ? idx_q + 2'd1 : idx_q;

        // A load on the commit edge is captured as the next pending value,
        // while the commit itself uses the registers held before the edge.
        pend_d_d  = load ? digits_in : pend_d_q;
        pend_dp_d = load ? dp_in     : pend_dp_q;
        pend_lz_d = load ? blank_lz  : pend_lz_q;
        pending_d = load ? 1'b1 : (commit ? 1'b0 : pending_q);

        disp_d_d  = commit ? pend_d_q  : disp_d_q;
        disp_dp_d = commit ? pend_dp_q : disp_dp_q;
        disp_lz_d = commit ? pend_lz_q : disp_lz_q;
        ack_d     = commit;

        // Blanking chains down from the most significant digit; digit 0 always shows.
        blank[3] = disp_lz_q && (disp_d_q[15:12] == 4'd0);
        blank[2] = blank[3] && (disp_d_q[11:8] == 4'd0);
        blank[1] = blank[2] && (disp_d_q[7:4] == 4'd0);
        blank[0] = 1'b0;

        sel_digit = disp_d_q[{idx_q, 2'b00} +: 4];
        bcd_out_d = blank[idx_q] ? 4'hF : sel_digit;
        an_d      = in_guard ? 4'b1111 : ~(4'b0001 << idx_q);
        dp_d      = in_guard ? 1'b1 : ~disp_dp_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q    <= '0;
            idx_q     <= '0;
            pend_d_q  <= '0;
            pend_dp_q <= '0;
            pend_lz_q <= 1'b0;
            pending_q <= 1'b0;
            disp_d_q  <= '0;
            disp_dp_q <= '0;
            disp_lz_q <= 1'b0;
            ack_q     <= 1'b0;
            bcd_out_q <= 4'hF;
            an_q      <= 4'b1111;
            dp_q      <= 1'b1;
        end else begin
            tcnt_q    <= tcnt_d;
            idx_q     <= idx_d;
            pend_d_q  <= pend_d_d;
            pend_dp_q <= pend_dp_d;
            pend_lz_q <= pend_lz_d;
            pending_q <= pending_d;
            disp_d_q  <= disp_d_d;
            disp_dp_q <= disp_dp_d;
            disp_lz_q <= disp_lz_d;
            ack_q     <= ack_d;
            bcd_out_q <= bcd_out_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign ack     = ack_q;
    assign pending = pending_q;
    assign bcd_out = bcd_out_q;
    assign an      = an_q;
    assign dp      = dp_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display in the temperature controller. It owns a single BCD-to-seven-segment decoder and shares it across the four digits, one digit per refresh slot. It drives the decoder's BCD input, the active-low anodes and the decimal point. New display values are handed over with a load/ack handshake and applied only at a frame boundary, so the display never shows a partial update.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot (must be ≥ 4).
- `GUARD`, default 16: cycles at the start of each slot with all anodes off, for anti-ghosting (must be < `REFRESH_DIV`).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle strobe that captures `digits_in`, `dp_in` and `blank_lz`.
- `digits_in`  in  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `dp_in`  in  4  decimal point enable per digit, active-high; bit i belongs to digit i.
- `blank_lz`  in  1  leading-zero blanking enable.
- `ack`  out  1  one-cycle pulse when pending data is committed to the display.
- `pending`  out  1  high while captured data is waiting for a frame boundary.
- `bcd_out`  out  4  to the decoder's `bcd` input; 4'hF means blank, and the decoder turns all segments off for it.
- `an`  out  4  anode enables, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- Slot counter `tcnt` counts 0..`REFRESH_DIV`-1 and wraps. Digit index `idx` is 2 bits, 0..3.
- When `tcnt` = `REFRESH_DIV`-1, `idx` advances, wrapping from 3 to 0. One frame is 4 slots.
- Data path: `load` writes the pending registers and sets `pending`. The display registers (`disp_d`, `disp_dp`, `disp_lz`) feed the scan.
- Commit happens on the edge where `tcnt` = `REFRESH_DIV`-1, `idx` = 3 and `pending` = 1:
  - pending registers move into the display registers;
  - `pending` clears;
  - `ack` is 1 for the following cycle.
- Multiple loads within one frame: the last one wins, and only one `ack` is issued.
- `load` on the commit edge: the commit uses the pending data held before that edge. The new data is captured as the next pending value and `pending` stays 1.
- Leading-zero blanking (when `disp_lz` = 1):
  - digit i (i = 3, 2, 1) is blanked when it and every higher digit equal 0;
  - digit 0 is never blanked.
- Digit values 10–15 in `digits_in` pass through unchanged; the decoder shows them blank.
- Registered outputs, computed from the current `idx` and `tcnt`:
  - `bcd_out` = the digit value, or 4'hF when that digit is blanked;
  - `an` = 4'b1111 when `tcnt` < `GUARD`, otherwise bit `idx` low and all other bits high;
  - `dp` = ~`disp_dp[idx]`, forced to 1 when `tcnt` < `GUARD`.

## Timing
- Reset values:
  - `tcnt` = 0, `idx` = 0;
  - display and pending registers = 0, `pending` = 0, `ack` = 0;
  - `an` = 4'b1111, `bcd_out` = 4'hF, `dp` = 1.
- Outputs lag `tcnt`/`idx` by one cycle because they are registered. `an` enables digit `idx` from slot cycle `GUARD`+1 to the end of the slot.
- `load` → `pending` = 1 on the next cycle.
- Worst-case `load` → `ack` latency is 4·`REFRESH_DIV` cycles.
- The first slot after a commit (digit 0) shows the new data.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous), and pending data is lost. After release, the scan restarts at digit 0 with `tcnt` = 0.
- A frame lasts exactly 4·`REFRESH_DIV` cycles with no stall. `load` never disturbs the scan timing.

## Test plan
All scenarios use `REFRESH_DIV` = 8 and `GUARD` = 2.
- Reset: assert `rst` mid-slot → on the same edge `an` = 1111, `bcd_out` = F, `dp` = 1, `ack` = 0, `pending` = 0. After release, `an` cycles 1110, 1101, 1011, 0111 with a period of 8 cycles each and 2 blank cycles per slot.
- Load/commit: `load` with `digits_in` = 16'h1234 at frame cycle 5 → `pending` = 1 on the next cycle. `ack` pulses once at frame end (cycle 32). The next frame's `bcd_out` sequence is 4, 3, 2, 1.
- Last-wins: loads of 16'h1111 and then 16'h2222 in the same frame → a single `ack`, and the display shows 2222.
- Simultaneous load: `load` of 16'h5678 on the commit edge of pending 16'h1234 → 1234 is committed with `ack`. `pending` stays 1, and 5678 commits at the following frame end.
- Blanking: `digits_in` = 16'h0050, `blank_lz` = 1 → `bcd_out` is 0, 5, F, F for digits 0..3. With `digits_in` = 16'h0000, `bcd_out` is 0, F, F, F. With `blank_lz` = 0, `bcd_out` is 0, 5, 0, 0.
- Decimal point: `dp_in` = 4'b0010 → `dp` = 0 only during the digit-1 slot after the guard cycles, and 1 everywhere else.
